// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes,
// line indices and the odd-parity helper used when a byte is accepted.
package ps2_pkg;

    // Transmit sequencer states, in frame order.
    typedef enum logic [2:0] {
        IDLE,       // waiting for a request
        INHIBIT,    // holding PS2C low before request-to-send
        RTS,        // start bit on PS2D, clock released, waiting for edge 1
        DATA,       // data bits on PS2D, edges 2..9 expected
        PARITY,     // parity bit on PS2D, waiting for edge 10
        STOP,       // PS2D released as stop bit, waiting for device to latch it
        ACK,        // waiting for edge 11 to sample the device ACK
        WAIT_IDLE   // waiting for both lines to return high
    } state_t;

    // Frequently used keyboard commands and the device acknowledge byte.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Bit positions of the two PS/2 lines in packed line vectors.
    localparam int LINE_C = 0;
    localparam int LINE_D = 1;

    // Number of data bits in a PS/2 frame.
    localparam int DATA_BITS = 8;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host
// transmitter. The source side is the master, the transmitter the slave.
interface ps2_host_tx_if;

    logic [7:0] tx_data;   // byte to send
    logic       tx_valid;  // request, taken when tx_valid && tx_ready
    logic       tx_ready;  // transmitter is idle and can take a byte
    logic       busy;      // a frame is in progress
    logic       done;      // one-cycle pulse at normal frame end
    logic       ack_ok;    // device acknowledged the last frame
    logic       error;     // one-cycle pulse on frame timeout

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_ok,
        output error
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 pin: two-flop synchronizer followed by a
// glitch filter that only changes its output after FILTER_LEN consecutive
// synchronized samples disagree with it. Edge strobes are one cycle wide and
// coincide with the cycle the filtered level changes.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin_in,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             fall_q;
    logic             fall_d;
    logic             rise_q;
    logic             rise_d;

    // Bring the raw pin into the clock domain; idle PS/2 lines are high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = 1'b0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state and edge strobe registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;
    assign rise  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// shifts one byte plus odd parity and stop out on device-generated clock
// falling edges, samples the device ACK and guards the frame with a timeout.
// Pins are open-drain: an *_oe of 1 pulls the line low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,    // must be at least 2
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] EDGE_PARITY = 4'(DATA_BITS);   // count before the parity edge
    localparam logic [3:0] EDGE_STOP   = 4'd10;
    localparam logic [3:0] EDGE_ACK    = 4'd11;

    // Conditioned line levels and edge strobes, indexed by LINE_C / LINE_D.
    logic [1:0] raw_pins;
    logic [1:0] line_level;
    logic [1:0] line_fall;
    logic [1:0] line_rise;

    assign raw_pins = {ps2d_in, ps2c_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        ps2_line_filter #(
            .FILTER_LEN (FILTER_LEN)
        ) u_filt (
            .clock   (clock),
            .reset_n (reset_n),
            .pin_in  (raw_pins[gi]),
            .level   (line_level[gi]),
            .fall    (line_fall[gi]),
            .rise    (line_rise[gi])
        );
    end

    // Only the clock line edges drive the sequencer; the data line is sampled by level.
    logic unused_d_edges;
    assign unused_d_edges = line_fall[LINE_D] ^ line_rise[LINE_D];

    logic c_fe;
    logic c_re;
    logic c_lvl;
    logic d_lvl;

    assign c_fe  = line_fall[LINE_C];
    assign c_re  = line_rise[LINE_C];
    assign c_lvl = line_level[LINE_C];
    assign d_lvl = line_level[LINE_D];

    state_t           state_q,     state_d;
    logic [7:0]       data_q,      data_d;
    logic             parity_q,    parity_d;
    logic [3:0]       edge_q,      edge_d;
    logic [INH_W-1:0] inh_q,       inh_d;
    logic [TMO_W-1:0] tmo_q,       tmo_d;
    logic             ps2c_oe_q,   ps2c_oe_d;
    logic             ps2d_oe_q,   ps2d_oe_d;
    logic             tx_ready_q,  tx_ready_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             ack_ok_q,    ack_ok_d;
    logic             error_q,     error_d;

    logic bit_phase;
    logic tmo_hit;
    logic next_bit;

    // Frame sequencer: next state, counters and all registered outputs.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        edge_d     = edge_q;
        inh_d      = inh_q;
        tmo_d      = tmo_q;
        ps2c_oe_d  = ps2c_oe_q;
        ps2d_oe_d  = ps2d_oe_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok_q;
        error_d    = 1'b0;

        // The timeout covers everything after the clock line is released.
        bit_phase = (state_q != IDLE) && (state_q != INHIBIT);
        tmo_hit   = bit_phase && (tmo_q == TMO_LAST);

        // Bit presented on the next clock edge: data LSB first, then parity.
        next_bit = (edge_q == EDGE_PARITY) ? parity_q : data_q[edge_q[2:0]];

        if (bit_phase) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (tmo_hit) begin
            // Timeout takes priority over any coincident clock edge.
            ps2c_oe_d = 1'b0;
            ps2d_oe_d = 1'b0;
            ack_ok_d  = 1'b0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    ps2c_oe_d  = 1'b0;
                    ps2d_oe_d  = 1'b0;
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    if (tx.tx_valid && tx_ready_q) begin
                        data_d     = tx.tx_data;
                        parity_d   = odd_parity(tx.tx_data);
                        ack_ok_d   = 1'b0;
                        busy_d     = 1'b1;
                        tx_ready_d = 1'b0;
                        ps2c_oe_d  = 1'b1;
                        inh_d      = '0;
                        state_d    = INHIBIT;
                    end
                end

                INHIBIT: begin
                    inh_d = inh_q + 1'b1;
                    // Start bit goes low during the final inhibit cycle.
                    if (inh_q == INH_PRE) begin
                        ps2d_oe_d = 1'b1;
                    end
                    if (inh_q == INH_LAST) begin
                        ps2c_oe_d = 1'b0;
                        tmo_d     = '0;
                        edge_d    = '0;
                        state_d   = RTS;
                    end
                end

                RTS, DATA: begin
                    if (c_fe) begin
                        edge_d    = edge_q + 4'd1;
                        ps2d_oe_d = ~next_bit;
                        state_d   = (edge_q == EDGE_PARITY) ? PARITY : DATA;
                    end
                end

                PARITY: begin
                    // Edge 10: stop bit is a released (high) line.
                    if (c_fe) begin
                        edge_d    = EDGE_STOP;
                        ps2d_oe_d = 1'b0;
                        state_d   = STOP;
                    end
                end

                STOP: begin
                    // Device latches the stop bit while the clock is high.
                    if (c_re) begin
                        state_d = ACK;
                    end
                end

                ACK: begin
                    if (c_fe) begin
                        edge_d   = EDGE_ACK;
                        ack_ok_d = ~d_lvl;
                        state_d  = WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (c_lvl && d_lvl) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer registers; reset releases both lines immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            edge_q     <= '0;
            inh_q      <= '0;
            tmo_q      <= '0;
            ps2c_oe_q  <= 1'b0;
            ps2d_oe_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            edge_q     <= edge_d;
            inh_q      <= inh_d;
            tmo_q      <= tmo_d;
            ps2c_oe_q  <= ps2c_oe_d;
            ps2d_oe_q  <= ps2d_oe_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
        end
    end

    assign ps2c_oe     = ps2c_oe_q;
    assign ps2d_oe     = ps2d_oe_q;
    assign tx.tx_ready = tx_ready_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
    assign tx.ack_ok   = ack_ok_q;
    assign tx.error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus model with a simple
// keyboard that clocks frames, records the bits it sees and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int FLT  = 8;
    localparam int HALF = 40;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ps2_host_tx_if tx_if ();

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2c_oe;
    logic ps2d_oe;
    logic ps2c_pin;
    logic ps2d_pin;

    // Wired-AND open-drain bus.
    assign ps2c_pin = dev_clk  & ~ps2c_oe;
    assign ps2d_pin = dev_data & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .tx      (tx_if),
        .ps2c_in (ps2c_pin),
        .ps2d_in (ps2d_pin),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int acc_cnt  = 0;
    logic [10:0] bits;

    always @(posedge clock) begin
        if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clock) begin
        if (tx_if.done === 1'b1)  done_cnt <= done_cnt + 1;
        if (tx_if.error === 1'b1) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        @(negedge clock);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        @(negedge clock);
        tx_if.tx_valid = 1'b0;
        check({tag, "_accept_busy"}, tx_if.busy, 1);
        $display("send %s data=%02h", tag, d);
    endtask

    // Keyboard model: measures inhibit, then clocks up to 11 edges.
    task automatic device_frame(input string tag, input bit do_ack, input int stop_after,
                                input int glitch_edge, output logic [10:0] fb);
        int n;
        fb = '0;
        n = 0;
        while (ps2c_pin !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        check({tag, "_inhibit_seen"}, ps2c_pin, 0);
        n = 0;
        while (ps2c_pin === 1'b0 && n < INH + 50) begin @(negedge clock); n++; end
        check({tag, "_inhibit_len"}, n, INH);
        fb[0] = ps2d_pin;
        repeat (20) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == stop_after) begin
                repeat (HALF / 2) @(negedge clock);
                return;
            end
            repeat (HALF) @(negedge clock);
            if (k <= 10) fb[k] = ps2d_pin;
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            if (k == 11) break;
            if (k == glitch_edge) begin
                repeat (15) @(negedge clock);
                dev_clk = 1'b0;
                repeat (3) @(negedge clock);
                dev_clk = 1'b1;
                repeat (HALF - 18) @(negedge clock);
            end else if (k == 10 && do_ack) begin
                repeat (HALF / 2) @(negedge clock);
                dev_data = 1'b0;
                repeat (HALF / 2) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_ack);
        int n;
        n = 0;
        while (tx_if.done !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        check({tag, "_done"}, tx_if.done, 1);
        check({tag, "_ack_ok"}, tx_if.ack_ok, exp_ack);
        check({tag, "_ready_at_done"}, tx_if.tx_ready, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, tx_if.done, 0);
        check({tag, "_ready_after_done"}, tx_if.tx_ready, 1);
        $display("frame %s done ack_ok=%0b", tag, exp_ack);
    endtask

    initial begin
        int n;
        int e0;
        int d0;
        int a0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ps2c_oe", ps2c_oe, 0);
        check("rst_ps2d_oe", ps2d_oe, 0);
        check("rst_busy", tx_if.busy, 0);
        check("rst_done", tx_if.done, 0);
        check("rst_error", tx_if.error, 0);
        check("rst_ack_ok", tx_if.ack_ok, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_tx_ready", tx_if.tx_ready, 1);

        // 0xED with ACK: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1
        send("set_led", CMD_SET_LED);
        device_frame("set_led", 1'b1, 0, 0, bits);
        check("set_led_bits", bits, 11'b11111011010);
        wait_done("set_led", 1'b1);

        // 0xF4 without ACK: parity 0
        e0 = err_cnt;
        send("enable", CMD_ENABLE);
        device_frame("enable", 1'b0, 0, 0, bits);
        check("enable_bits", bits, 11'b10111101000);
        wait_done("enable", 1'b0);
        check("enable_no_error", err_cnt, e0);

        // Device never clocks: error exactly TMO cycles after release
        d0 = done_cnt;
        send("timeout", CMD_RESET);
        n = 0;
        while (ps2c_pin !== 1'b0 && n < 50) begin @(negedge clock); n++; end
        n = 0;
        while (ps2c_pin === 1'b0 && n < INH + 50) begin @(negedge clock); n++; end
        n = 0;
        while (tx_if.error !== 1'b1 && n < TMO + 50) begin @(negedge clock); n++; end
        check("tmo_cycles", n, TMO);
        check("tmo_ps2c_oe", ps2c_oe, 0);
        check("tmo_ps2d_oe", ps2d_oe, 0);
        check("tmo_ack_ok", tx_if.ack_ok, 0);
        check("tmo_ready_at_error", tx_if.tx_ready, 0);
        @(negedge clock);
        check("tmo_ready_after", tx_if.tx_ready, 1);
        check("tmo_error_one_cycle", tx_if.error, 0);
        check("tmo_no_done", done_cnt, d0);
        $display("frame timeout error after %0d cycles", n);

        // tx_valid held with changing data: only 0x3C goes out (parity 1)
        a0 = acc_cnt;
        @(negedge clock);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h3C;
        @(negedge clock);
        check("held_accept_busy", tx_if.busy, 1);
        fork
            device_frame("held", 1'b1, 0, 0, bits);
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat (50) @(negedge clock);
                    tx_if.tx_data = 8'(i * 17 + 1);
                end
                tx_if.tx_data = CMD_RESET;
            end
        join
        check("held_bits", bits, 11'b11001111000);
        check("held_single_accept", acc_cnt - a0, 1);
        wait_done("held", 1'b1);
        @(negedge clock);
        tx_if.tx_valid = 1'b0;
        check("held_second_accept", acc_cnt - a0, 2);
        check("held_second_busy", tx_if.busy, 1);

        // Second frame carries 0xFF with a 3-cycle clock glitch after edge 4
        device_frame("glitch", 1'b1, 0, 4, bits);
        check("glitch_bits", bits, 11'b11111111110);
        wait_done("glitch", 1'b1);

        // Reset at edge 5 of a 0xED frame (bit 4 is 0, so PS2D is driven)
        send("rst_mid", CMD_SET_LED);
        device_frame("rst_mid", 1'b1, 5, 0, bits);
        check("rst_mid_d_driven", ps2d_oe, 1);
        check("rst_mid_c_released", ps2c_oe, 0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ps2c_oe", ps2c_oe, 0);
        check("rst_mid_ps2d_oe", ps2d_oe, 0);
        check("rst_mid_busy", tx_if.busy, 0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_mid_ready", tx_if.tx_ready, 1);
        check("rst_mid_busy_after", tx_if.busy, 0);
        $display("reset mid-frame handled");

        // 0x00 after reset: parity 1
        send("zero", 8'h00);
        device_frame("zero", 1'b1, 0, 0, bits);
        check("zero_bits", bits, 11'b11000000000);
        wait_done("zero", 1'b1);

        repeat (2) @(negedge clock);
        check("total_dones", done_cnt, 5);
        check("total_errors", err_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
